// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and seven-segment encodings ({dp,g,f,e,d,c,b,a}, active high).
package stopwatch_pkg;

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        RUNNING = 3'd1,
        STOPPED = 3'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_t;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    localparam logic [7:0] SEG_C    = 8'h39;
    localparam logic [7:0] SEG_R    = 8'h50;
    localparam logic [7:0] SEG_S    = 8'h6D;
    localparam logic [7:0] SEG_DASH = 8'h40;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] seg;
        seg = 8'h00;
        if (d <= 4'd9) begin
            seg = SEG_DIGIT[d];
        end
        return seg;
    endfunction

    function automatic logic [7:0] seg_mode(input logic [2:0] m);
        logic [7:0] seg;
        case (m)
            CLEAR:   seg = SEG_C;
            RUNNING: seg = SEG_R;
            STOPPED: seg = SEG_S;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/stopwatch_display_bin2bcd.sv
// Sequential double-dabble: 5-bit binary to two BCD digits in five shift iterations.
module bin2bcd_seq
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [4:0] bin_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    conv_state_t state_q, state_d;
    logic [12:0] sreg_q, sreg_d;
    logic [2:0]  iter_q, iter_d;
    logic [12:0] adj;
    logic [12:0] shifted;

    always_comb begin
        adj = sreg_q;
        if (sreg_q[12:9] >= 4'd5) begin
            adj[12:9] = sreg_q[12:9] + 4'd3;
        end
        if (sreg_q[8:5] >= 4'd5) begin
            adj[8:5] = sreg_q[8:5] + 4'd3;
        end
        shifted = {adj[11:0], 1'b0};
    end

    // The LOAD edge performs the first shift, so the digits are final one edge before DONE.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        iter_d  = iter_q;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    sreg_d  = {8'b0, bin_i};
                    iter_d  = 3'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sreg_d  = shifted;
                iter_d  = iter_q + 3'd1;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (iter_q == 3'd5) begin
                    done_o  = 1'b1;
                    state_d = DONE;
                end else begin
                    sreg_d = shifted;
                    iter_d = iter_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            iter_q  <= iter_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign tens_o = sreg_q[12:9];
    assign ones_o = sreg_q[8:5];

endmodule

// File: rtl/stopwatch_display.sv
// Stopwatch display back-end: mode letter, blanked/blinking two-digit time on seven-segment outputs.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int unsigned BLINK_HALF = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] mode_i,
    input  logic [4:0] time_i,
    output logic [7:0] ss7_o,
    output logic [7:0] ss1_o,
    output logic [7:0] ss0_o,
    output logic       busy_o
);

    localparam int unsigned BlinkW = (2 * BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;
    localparam logic [BlinkW-1:0] BlinkMax  = BlinkW'(2 * BLINK_HALF - 1);
    localparam logic [BlinkW-1:0] BlinkHalf = BlinkW'(BLINK_HALF);

    logic [2:0]        mode_q;
    logic [4:0]        time_q, conv_val_q;
    logic              valid_q, valid_d;
    logic [3:0]        tens_q, tens_d, ones_q, ones_d;
    logic [BlinkW-1:0] blink_q, blink_d;
    logic [7:0]        ss7_q, ss7_d, ss1_q, ss1_d, ss0_q, ss0_d;
    logic              start, show;
    logic              conv_busy, conv_done;
    logic [3:0]        conv_tens, conv_ones;

    // Only sampled by the converter in IDLE, so a change mid-conversion waits its turn.
    assign start = !valid_q || (time_q != conv_val_q);

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .bin_i   (time_q),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .tens_o  (conv_tens),
        .ones_o  (conv_ones)
    );

    always_comb begin
        valid_d = valid_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        if (conv_done) begin
            valid_d = 1'b1;
            tens_d  = conv_tens;
            ones_d  = conv_ones;
        end

        blink_d = '0;
        if (mode_q == STOPPED) begin
            blink_d = (blink_q == BlinkMax) ? '0 : blink_q + BlinkW'(1);
        end
        show = (mode_q != STOPPED) || (blink_q < BlinkHalf);

        ss7_d = seg_mode(mode_q);
        ss1_d = 8'h00;
        ss0_d = 8'h00;
        if (valid_d && show) begin
            ss1_d = (tens_d == 4'd0) ? 8'h00 : seg_digit(tens_d);
            ss0_d = seg_digit(ones_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= '0;
            time_q     <= '0;
            conv_val_q <= '0;
            valid_q    <= 1'b0;
            tens_q     <= '0;
            ones_q     <= '0;
            blink_q    <= '0;
            ss7_q      <= '0;
            ss1_q      <= '0;
            ss0_q      <= '0;
        end else begin
            mode_q <= mode_i;
            time_q <= time_i;
            if (start && !conv_busy) begin
                conv_val_q <= time_q;
            end
            valid_q <= valid_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            blink_q <= blink_d;
            ss7_q   <= ss7_d;
            ss1_q   <= ss1_d;
            ss0_q   <= ss0_d;
        end
    end

    assign ss7_o  = ss7_q;
    assign ss1_o  = ss1_q;
    assign ss0_o  = ss0_q;
    assign busy_o = conv_busy;

endmodule
